// File: rtl/count_pwm_pkg.sv
// Shared types and defaults for the counter-driven PWM block and its helpers.
package count_pwm_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, RUN} pwm_state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] DUTY_RST_DEF = 8'h80;
endpackage

// File: rtl/count_wrap_det.sv
// Detects a wrap of an upstream counter: any step to a smaller value, including
// an upstream reset mid-count. A held value is never a wrap.
module count_wrap_det #(
  parameter int WIDTH = count_pwm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] cnt,
  output logic             wrap
);
  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!res) cnt_q <= '0;
    else      cnt_q <= cnt;
  end

  assign wrap = (cnt < cnt_q);
endmodule

// File: rtl/count_pwm.sv
// PWM generator comparing an upstream counter against a duty value; new duty
// values are staged in a shadow register and applied only at counter wrap.
module count_pwm
  import count_pwm_pkg::*;
#(
  parameter int               WIDTH    = CNT_W,
  parameter logic [WIDTH-1:0] DUTY_RST = DUTY_RST_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] cnt,
  input  logic             en,
  input  logic             duty_valid,
  input  logic [WIDTH-1:0] duty_in,
  output logic             duty_ready,
  output logic             pwm,
  output logic             period_tick,
  output logic [WIDTH-1:0] duty_active
);
  pwm_state_t       state;
  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             wrap;
  logic             xfer;
  logic             swap;
  logic [WIDTH-1:0] duty_use;
  logic             cmp;

  count_wrap_det #(.WIDTH(WIDTH)) u_wrap (
    .clk  (clk),
    .res  (res),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // Load port: a value transfers on any edge with duty_valid & duty_ready;
  // the producer holds duty_in stable while valid is high and ready is low.
  assign duty_ready = ~pending;
  assign xfer       = duty_valid & duty_ready;
  assign swap       = wrap & pending;

  // The wrap-cycle compare already sees the incoming duty so the new period starts clean.
  assign duty_use = swap ? shadow : duty_active;
  assign cmp      = (cnt < duty_use);

  always_ff @(posedge clk) begin
    if (!res) begin
      state       <= IDLE;
      pwm         <= 1'b0;
      period_tick <= 1'b0;
      duty_active <= DUTY_RST;
      shadow      <= '0;
      pending     <= 1'b0;
    end else begin
      period_tick <= wrap;

      if (swap) begin
        duty_active <= shadow;
        pending     <= 1'b0;
      end else if (xfer) begin
        shadow  <= duty_in;
        pending <= 1'b1;
      end

      if (!en) begin
        state <= IDLE;
        pwm   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SYNC;
            pwm   <= 1'b0;
          end
          SYNC: begin
            if (wrap) begin
              state <= RUN;
              pwm   <= cmp;
            end else begin
              pwm <= 1'b0;
            end
          end
          RUN:     pwm <= cmp;
          default: begin
            state <= IDLE;
            pwm   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_count_pwm.sv
// Bench for count_pwm: drives an 8-bit free-running counter and checks outputs
// against a period-level reference built from the duty/handshake rules.
module tb_count_pwm;
  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b0;
  logic       duty_valid = 1'b0;
  logic [7:0] cnt = 8'd0;
  logic [7:0] duty_in = 8'd0;
  logic       duty_ready;
  logic       pwm;
  logic       period_tick;
  logic [7:0] duty_active;

  int n_checks = 0;
  int n_fail = 0;

  // reference model
  logic [7:0] m_prev = 8'd0;
  logic [7:0] exp_active = 8'h80;
  logic [7:0] exp_q[$];
  bit         running = 1'b0;
  bit         en_prev = 1'b0;
  bit         exp_tick = 1'b0;
  bit         xfer_seen = 1'b0;
  bit         p_valid = 1'b0;
  int         p_len = 0;
  int         p_hi = 0;
  logic [7:0] p_duty = 8'd0;
  int         clr_at = -1;
  int         tick_cnt = 0;

  count_pwm dut (
    .clk         (clk),
    .res         (res),
    .cnt         (cnt),
    .en          (en),
    .duty_valid  (duty_valid),
    .duty_in     (duty_in),
    .duty_ready  (duty_ready),
    .pwm         (pwm),
    .period_tick (period_tick),
    .duty_active (duty_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: sample after the edge, update the model from the inputs that
  // were applied at that edge, compare, then advance the upstream counter.
  task automatic step();
    bit w;
    bit xfer;
    int exp_hi;
    @(posedge clk);
    #1;
    w = 1'b0;
    xfer = 1'b0;
    if (!res) begin
      m_prev = 8'd0;
      exp_active = 8'h80;
      exp_q.delete();
      running = 1'b0;
      en_prev = 1'b0;
      exp_tick = 1'b0;
      p_valid = 1'b0;
    end else begin
      w = (cnt < m_prev);
      exp_tick = w;
      xfer = duty_valid && (exp_q.size() == 0);
      if (w && exp_q.size() > 0) exp_active = exp_q.pop_front();
      if (xfer) exp_q.push_back(duty_in);
      if (!en) running = 1'b0;
      else if (!running && en_prev && w) running = 1'b1;
      en_prev = en;
      m_prev = cnt;
    end
    xfer_seen = xfer;
    if (exp_tick) tick_cnt++;

    check("period_tick", 32'(period_tick), 32'(exp_tick));
    check("duty_active", 32'(duty_active), 32'(exp_active));
    check("duty_ready", 32'(duty_ready), 32'(exp_q.size() == 0));
    if (!running) check("pwm_off", 32'(pwm), 32'd0);

    if (w) begin
      if (p_valid) begin
        exp_hi = (p_len < int'(p_duty)) ? p_len : int'(p_duty);
        check("period_high", 32'(p_hi), 32'(exp_hi));
      end
      p_valid = running;
      p_duty = exp_active;
      p_len = 0;
      p_hi = 0;
    end
    p_len++;
    p_hi += int'(pwm);
    if (!running) p_valid = 1'b0;

    if (!res) cnt = 8'd0;
    else if (clr_at >= 0 && cnt == clr_at[7:0]) begin
      cnt = 8'd0;
      clr_at = -1;
    end else cnt = cnt + 8'd1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int i;
    for (i = 0; i < 600 && cnt != v; i++) step();
    if (cnt != v) check("wait_cnt_timeout", 32'(cnt), 32'(v));
  endtask

  task automatic load(input logic [7:0] v);
    int i;
    duty_valid = 1'b1;
    duty_in = v;
    xfer_seen = 1'b0;
    for (i = 0; i < 600 && !xfer_seen; i++) step();
    duty_valid = 1'b0;
    if (!xfer_seen) check("load_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    res = 1'b0;
    step();
    step();
    res = 1'b1;

    // disabled: ticks still pulse once per 256 cycles
    run(20);
    tick_cnt = 0;
    run(512);
    check("idle_tick_count", 32'(tick_cnt), 32'd2);

    // enable mid-count: output waits for a whole period
    wait_cnt(8'd100);
    en = 1'b1;
    run(600);

    // load during a period, applied at the next wrap
    wait_cnt(8'd10);
    load(8'h40);
    run(600);

    // load coinciding with the wrap cycle is applied one period later
    wait_cnt(8'd0);
    load(8'h20);
    run(300);
    check("late_swap_value", 32'(duty_active), 32'h20);
    run(300);

    // duty extremes and an upstream counter reset
    load(8'h00);
    run(600);
    load(8'hFF);
    run(600);
    wait_cnt(8'd50);
    load(8'h30);
    clr_at = 150;
    run(400);

    // reset with a pending value while running
    wait_cnt(8'd20);
    load(8'h10);
    run(5);
    res = 1'b0;
    step();
    res = 1'b1;
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_duty", 32'(duty_active), 32'h80);
    check("rst_ready", 32'(duty_ready), 32'd1);
    run(600);

    // randomized mix of loads, enable drops and upstream resets
    repeat (30) begin
      case ($urandom_range(0, 3))
        0, 1: load(8'($urandom_range(0, 255)));
        2: begin
          en = 1'b0;
          run($urandom_range(1, 5));
          en = 1'b1;
        end
        default: clr_at = $urandom_range(0, 254);
      endcase
      run($urandom_range(1, 300));
    end
    run(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
